// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Load, control and instruction-issue bundle of instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              stall;
    logic [7:0]        instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              running;
    logic              halted;
    logic [7:0]        issue_count;

    modport master (
        output load_en, load_addr, load_data, start, start_addr, stall,
        input  instr, instr_valid, pc, running, halted, issue_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, start_addr, stall,
        output instr, instr_valid, pc, running, halted, issue_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Program memory plus fetch/issue FSM that drives a processor's
//               8-bit instruction input, padding with NOPs and stopping on HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] HALT_OP = 8'h13,
    parameter logic [7:0] NOP_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);

    localparam int              c_DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_mem [c_DEPTH];
    logic [7:0]        r_instr_reg;
    logic [7:0]        r_instr;
    logic              r_instr_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              r_running;
    logic              r_halted;
    logic [7:0]        r_issue_count;

    logic              w_ctrl_open;
    logic              w_load_ok;

    // Loads and starts are only honoured while nothing is executing.
    assign w_ctrl_open = (r_state == S_IDLE) || (r_state == S_HALTED);
    assign w_load_ok   = !rst && bus.load_en && w_ctrl_open;

    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr_reg   <= NOP_OP;
            r_instr       <= NOP_OP;
            r_instr_valid <= 1'b0;
            r_running     <= 1'b0;
            r_halted      <= 1'b0;
            r_issue_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        r_state       <= S_FETCH;
                        r_pc          <= bus.start_addr;
                        r_issue_count <= 8'd0;
                        r_running     <= 1'b1;
                        r_halted      <= 1'b0;
                    end
                    r_instr       <= NOP_OP;
                    r_instr_valid <= 1'b0;
                end
                S_FETCH: begin
                    r_instr_reg   <= r_mem[r_pc];
                    r_instr       <= r_mem[r_pc];
                    r_instr_valid <= 1'b1;
                    r_state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!bus.stall) begin
                        if (r_issue_count != 8'hFF) begin
                            r_issue_count <= r_issue_count + 8'd1;
                        end
                        r_instr       <= NOP_OP;
                        r_instr_valid <= 1'b0;
                        if (r_instr_reg == HALT_OP) begin
                            r_state   <= S_HALTED;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_pc    <= r_pc + c_PC_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.running     = r_running;
    assign bus.halted      = r_halted;
    assign bus.issue_count = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed vector table, saturation run and randomized programs
//               checked against an instruction-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int         c_AW   = 4;
    localparam logic [7:0] c_HALT = 8'h13;
    localparam logic [7:0] c_NOP  = 8'hFF;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    instr_sequencer_if #(.ADDR_W(c_AW)) bus ();

    instr_sequencer #(
        .ADDR_W (c_AW),
        .HALT_OP(c_HALT),
        .NOP_OP (c_NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] la;
        logic [7:0] ldd;
        logic       st;
        logic [3:0] sa;
        logic       stl;
        logic [7:0] e_instr;
        logic       e_v;
        logic [3:0] e_pc;
        logic       e_run;
        logic       e_halt;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ld, logic [3:0] la, logic [7:0] ldd,
                                logic st, logic [3:0] sa, logic stl,
                                logic [7:0] ei, logic ev, logic [3:0] ep,
                                logic er, logic eh, logic [7:0] ec);
        vec_t v;
        v.rst = r; v.ld = ld; v.la = la; v.ldd = ldd; v.st = st; v.sa = sa; v.stl = stl;
        v.e_instr = ei; v.e_v = ev; v.e_pc = ep; v.e_run = er; v.e_halt = eh; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic ld, logic [3:0] la, logic [7:0] ldd,
                         logic st, logic [3:0] sa, logic stl);
        rst            = r;
        bus.load_en    = ld;
        bus.load_addr  = la;
        bus.load_data  = ldd;
        bus.start      = st;
        bus.start_addr = sa;
        bus.stall      = stl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(int i, vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        chk({t, "_instr"}, 32'(bus.instr), 32'(v.e_instr));
        chk({t, "_valid"}, 32'(bus.instr_valid), 32'(v.e_v));
        chk({t, "_pc"}, 32'(bus.pc), 32'(v.e_pc));
        chk({t, "_running"}, 32'(bus.running), 32'(v.e_run));
        chk({t, "_halted"}, 32'(bus.halted), 32'(v.e_halt));
        chk({t, "_count"}, 32'(bus.issue_count), 32'(v.e_cnt));
    endtask

    logic [7:0] model_mem [16];
    int         exp_addr[$];

    initial begin
        total = 0;
        bad   = 0;
        drive(1, 0, 0, 0, 0, 0, 0);

        // reset, load, basic run with a 3-cycle stall on 0x01
        vecs.push_back(mk(1,0,0,8'h00,0,0,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,8'h00,0,0,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,1,1,8'h01,0,0,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,1,2,8'h13,0,0,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1,0,0, 8'hFF,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h01,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,1, 8'h01,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,1, 8'h01,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,1, 8'h01,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,2,1,0,2));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h13,1,2,1,0,2));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,2,0,1,3));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,2,0,1,3));
        // restart from HALTED; load/start during FETCH and ISSUE are ignored
        vecs.push_back(mk(0,0,0,8'h00,1,0,0, 8'hFF,0,0,1,0,0));
        vecs.push_back(mk(0,1,1,8'h07,1,5,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(0,1,1,8'h07,1,5,0, 8'hFF,0,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h01,1,1,1,0,1));
        // reset mid-ISSUE, then replay from memory
        vecs.push_back(mk(1,0,0,8'h00,0,0,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1,0,0, 8'hFF,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h01,1,1,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,2,1,0,2));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h13,1,2,1,0,2));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,2,0,1,3));
        // reset beats simultaneous start and load
        vecs.push_back(mk(1,1,0,8'hAA,1,3,0, 8'hFF,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,8'h00,1,0,0, 8'hFF,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h00,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,8'h00,0,0,0, 8'hFF,0,0,0,0,0));
        // load and start same cycle, same address: fetch sees the new word
        vecs.push_back(mk(0,1,4,8'h13,1,4,0, 8'hFF,0,4,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h13,1,4,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,4,0,1,1));
        // address wrap 15 -> 0
        vecs.push_back(mk(0,1,15,8'h05,0,0,0, 8'hFF,0,4,0,1,1));
        vecs.push_back(mk(0,1,0,8'h13,0,0,0, 8'hFF,0,4,0,1,1));
        vecs.push_back(mk(0,0,0,8'h00,1,15,0, 8'hFF,0,15,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h05,1,15,1,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'h13,1,0,1,0,1));
        vecs.push_back(mk(0,0,0,8'h00,0,0,0, 8'hFF,0,0,0,1,2));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].la, vecs[i].ldd,
                  vecs[i].st, vecs[i].sa, vecs[i].stl);
            step();
            check_vec(i, vecs[i]);
        end

        // saturation: a program with no HALT keeps issuing past 255
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 4'(a), 8'h00, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2 * 260) step();
        chk("sat_count", 32'(bus.issue_count), 32'd255);
        chk("sat_running", 32'(bus.running), 32'd1);

        // randomized programs with random stalls
        for (int it = 0; it < 20; it++) begin
            int         h;
            int         a;
            int         k;
            int         cyc;
            logic [3:0] sa;
            logic       prev_valid;
            logic       stl;

            drive(1, 0, 0, 0, 0, 0, 0);
            step();
            for (int m = 0; m < 16; m++) model_mem[m] = 8'($urandom);
            h = int'($urandom % 16);
            model_mem[h] = c_HALT;
            for (int m = 0; m < 16; m++) begin
                drive(0, 1, 4'(m), model_mem[m], 0, 0, 0);
                step();
            end
            sa = 4'($urandom);
            exp_addr.delete();
            a = int'(sa);
            forever begin
                exp_addr.push_back(a);
                if (model_mem[a] == c_HALT) break;
                a = (a + 1) % 16;
            end

            drive(0, 0, 0, 0, 1, sa, 0);
            step();
            k   = 0;
            cyc = 0;
            while (!bus.halted && cyc < 200) begin
                stl        = ($urandom % 3) == 0;
                prev_valid = bus.instr_valid;
                drive(0, 0, 0, 0, 0, 0, stl);
                if (bus.instr_valid && k < exp_addr.size()) begin
                    chk($sformatf("r%0d_instr%0d", it, k), 32'(bus.instr),
                        32'(model_mem[exp_addr[k]]));
                    chk($sformatf("r%0d_pc%0d", it, k), 32'(bus.pc), 32'(exp_addr[k]));
                end else if (!bus.instr_valid) begin
                    chk($sformatf("r%0d_nop", it), 32'(bus.instr), 32'(c_NOP));
                end
                step();
                if (prev_valid && !stl) k++;
                cyc++;
            end
            chk($sformatf("r%0d_halted", it), 32'(bus.halted), 32'd1);
            chk($sformatf("r%0d_accepts", it), 32'(k), 32'(exp_addr.size()));
            chk($sformatf("r%0d_count", it), 32'(bus.issue_count), 32'(exp_addr.size()));
            chk($sformatf("r%0d_final_pc", it), 32'(bus.pc),
                32'(exp_addr[exp_addr.size()-1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
